// File: rtl/controle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | controle_pkg                                                               |
// | Shared definitions for the iZero multi-cycle control sequencer: state      |
// | codes, opcode/function encodings, PC/write-back/ALU select codes, the      |
// | instruction-class enum, the decoded control word and its decoder.          |
// | Revision: 1.0 - initial multi-cycle release                                |
// +----------------------------------------------------------------------------+
package controle_pkg;

  // Sequencer states, kept as plain constants so older netlists and
  // waveform scripts that expect raw codes keep working.
  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH   = 3'd0;
  localparam state_t ST_DECODE  = 3'd1;
  localparam state_t ST_EXEC    = 3'd2;
  localparam state_t ST_MEM     = 3'd3;
  localparam state_t ST_IO_WAIT = 3'd4;
  localparam state_t ST_WB      = 3'd5;
  localparam state_t ST_INTR    = 3'd6;
  localparam state_t ST_HALT    = 3'd7;

  // iZero primary opcodes
  localparam logic [5:0] OP_R          = 6'h00;
  localparam logic [5:0] OP_J          = 6'h02;
  localparam logic [5:0] OP_JF         = 6'h04;
  localparam logic [5:0] OP_ADDI       = 6'h08;
  localparam logic [5:0] OP_SLTI       = 6'h0A;
  localparam logic [5:0] OP_ANDI       = 6'h0C;
  localparam logic [5:0] OP_ORI        = 6'h0D;
  localparam logic [5:0] OP_IN         = 6'h1C;
  localparam logic [5:0] OP_LW         = 6'h23;
  localparam logic [5:0] OP_SW         = 6'h2B;
  localparam logic [5:0] OP_SYSCALL    = 6'h30;
  localparam logic [5:0] OP_CIC        = 6'h31;
  localparam logic [5:0] OP_GIC        = 6'h32;
  localparam logic [5:0] OP_GIP        = 6'h33;
  localparam logic [5:0] OP_EXEC       = 6'h34;
  localparam logic [5:0] OP_EXEC_AGAIN = 6'h35;
  localparam logic [5:0] OP_HALT       = 6'h3F;

  // R-type function field
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // PC mux select
  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_REG    = 2'd2;
  localparam logic [1:0] PC_VECTOR = 2'd3;

  // Destination register select
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  // Write-back data select. The input port shares the memory read-data
  // path, so 'in' writes back through WS_MEM.
  localparam logic [1:0] WS_ALU     = 2'd0;
  localparam logic [1:0] WS_MEM     = 2'd1;
  localparam logic [1:0] WS_INTCODE = 2'd2;
  localparam logic [1:0] WS_PENDING = 2'd3;

  // ALU operations
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_SLT = 5'd5;

  // CL_NOP is encoded as zero so an all-zero control word is a no-op.
  typedef enum logic [3:0] {
    CL_NOP   = 4'd0,
    CL_ALU_R = 4'd1,
    CL_ALU_I = 4'd2,
    CL_LOAD  = 4'd3,
    CL_STORE = 4'd4,
    CL_IN    = 4'd5,
    CL_JUMP  = 4'd6,
    CL_SYS   = 4'd7,
    CL_HALT  = 4'd8
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [4:0] alu_op;
    logic       alu_src_reg;  // 1: operand B from register file
    logic       reg_write;
    logic [1:0] reg_dest;
    logic [1:0] wrt_sel;
    logic [1:0] pc_src;
    logic       is_cond;      // PC redirect depends on isFalse
    logic       set_kernel;
    logic       clr_kernel;
    logic       clr_pend;
  } ctrl_t;

  function automatic ctrl_t decode_instr(input logic [5:0] op, input logic [5:0] func);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R: begin
        c.alu_src_reg = 1'b1;
        c.reg_write   = 1'b1;
        c.reg_dest    = RD_RD;
        c.wrt_sel     = WS_ALU;
        c.cls         = CL_ALU_R;
        case (func)
          FN_ADD: c.alu_op = ALU_ADD;
          FN_SUB: c.alu_op = ALU_SUB;
          FN_AND: c.alu_op = ALU_AND;
          FN_OR:  c.alu_op = ALU_OR;
          FN_XOR: c.alu_op = ALU_XOR;
          FN_SLT: c.alu_op = ALU_SLT;
          FN_JR: begin
            c.cls       = CL_JUMP;
            c.reg_write = 1'b0;
            c.reg_dest  = RD_RT;
            c.pc_src    = PC_REG;
          end
          default: c = '0;  // unknown function: no-op
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        c.cls       = CL_ALU_I;
        c.reg_write = 1'b1;
        c.reg_dest  = RD_RT;
        c.wrt_sel   = WS_ALU;
        case (op)
          OP_SLTI: c.alu_op = ALU_SLT;
          OP_ANDI: c.alu_op = ALU_AND;
          OP_ORI:  c.alu_op = ALU_OR;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      OP_LW: begin
        c.cls       = CL_LOAD;
        c.alu_op    = ALU_ADD;
        c.reg_write = 1'b1;
        c.reg_dest  = RD_RT;
        c.wrt_sel   = WS_MEM;
      end
      OP_SW: begin
        c.cls    = CL_STORE;
        c.alu_op = ALU_ADD;
      end
      OP_IN: begin
        c.cls       = CL_IN;
        c.reg_write = 1'b1;
        c.reg_dest  = RD_RT;
        c.wrt_sel   = WS_MEM;
      end
      OP_J: begin
        c.cls    = CL_JUMP;
        c.pc_src = PC_BRANCH;
      end
      OP_JF: begin
        c.cls         = CL_JUMP;
        c.alu_op      = ALU_SUB;
        c.alu_src_reg = 1'b1;
        c.pc_src      = PC_BRANCH;
        c.is_cond     = 1'b1;
      end
      OP_SYSCALL: begin
        c.cls        = CL_SYS;
        c.pc_src     = PC_VECTOR;
        c.set_kernel = 1'b1;
      end
      OP_CIC: begin
        c.cls      = CL_SYS;
        c.clr_pend = 1'b1;
      end
      OP_GIC, OP_GIP: begin
        c.cls       = CL_SYS;
        c.reg_write = 1'b1;
        c.reg_dest  = RD_RT;
        c.wrt_sel   = (op == OP_GIC) ? WS_INTCODE : WS_PENDING;
      end
      OP_EXEC, OP_EXEC_AGAIN: begin
        c.cls        = CL_SYS;
        c.pc_src     = PC_REG;
        c.clr_kernel = 1'b1;
      end
      OP_HALT: c.cls = CL_HALT;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/controle_multiciclo_irq_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irq_prio_enc                                                               |
// | Pending-interrupt register with a lowest-index-first priority encoder.    |
// | Ports: clk, rst (async, active-low), set_vec (bits to raise), clr_en /    |
// |        clr_idx (bit to clear; a simultaneous set wins), any_pending,       |
// |        top_idx (lowest pending channel).                                   |
// | Revision: 1.0 - initial multi-cycle release                                |
// +----------------------------------------------------------------------------+
module irq_prio_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IRQ-1:0]         set_vec,
  input  logic                       clr_en,
  input  logic [$clog2(NUM_IRQ)-1:0] clr_idx,
  output logic                       any_pending,
  output logic [$clog2(NUM_IRQ)-1:0] top_idx
);
  localparam int IW = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] clr_mask;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_clr
    assign clr_mask[i] = clr_en && (clr_idx == IW'(i));
  end

  // Set is OR-ed in after the clear so a request arriving in the clearing
  // cycle is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_vec;
    end
  end

  // Scan from the top down so the lowest index is the last to assign.
  always_comb begin
    top_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) top_idx = IW'(i);
    end
  end

  assign any_pending = |pending;

endmodule
`default_nettype wire

// File: rtl/controle_multiciclo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | controle_multiciclo                                                        |
// | Multi-cycle control sequencer for the iZero processor: FETCH, DECODE,     |
// | EXEC, MEM, IO_WAIT, WB, INTR, HALT, with a prioritised interrupt entry at  |
// | instruction boundaries and a memory-timeout bus error.                     |
// | Inputs : clk, rst (async, active-low), op, func, isFalse, btn, irq,        |
// |          memReady.                                                         |
// | Outputs: irWrite, pcWrite, pcSource, regWrite, regDest, regWrtSelect,      |
// |          isRegAluOp, aluOp, memRead, memWrite, inta, intCode, kernelMode,  |
// |          busError, isHalt. All outputs decode registered state only.       |
// | Revision: 1.0 - initial multi-cycle release                                |
// +----------------------------------------------------------------------------+
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int NUM_IRQ     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [5:0]                 op,
  input  logic [5:0]                 func,
  input  logic                       isFalse,
  input  logic                       btn,
  input  logic [NUM_IRQ-1:0]         irq,
  input  logic                       memReady,
  output logic                       irWrite,
  output logic                       pcWrite,
  output logic [1:0]                 pcSource,
  output logic                       regWrite,
  output logic [1:0]                 regDest,
  output logic [1:0]                 regWrtSelect,
  output logic                       isRegAluOp,
  output logic [4:0]                 aluOp,
  output logic                       memRead,
  output logic                       memWrite,
  output logic                       inta,
  output logic [$clog2(NUM_IRQ)-1:0] intCode,
  output logic                       kernelMode,
  output logic                       busError,
  output logic                       isHalt
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t                     state;
  state_t                     next_state;
  ctrl_t                      ctrl;
  logic                       armed;
  logic                       branch_taken;
  logic [CNT_W-1:0]           mem_cnt;
  logic                       mem_fault;
  logic                       bus_error;
  logic                       kernel_mode;
  logic [$clog2(NUM_IRQ)-1:0] int_code;
  logic                       btn_q;

  logic                       timeout_hit;
  logic                       btn_rise;
  logic [NUM_IRQ-1:0]         set_vec;
  logic                       clr_en;
  logic                       any_pending;
  logic [$clog2(NUM_IRQ)-1:0] top_idx;

  // A completion arriving in the last allowed cycle still counts as success.
  assign timeout_hit = (state == ST_MEM) && !memReady && (mem_cnt == CNT_W'(MEM_TIMEOUT));
  assign btn_rise    = btn && !btn_q;
  assign clr_en      = (state == ST_WB) && ctrl.clr_pend;

  always_comb begin
    set_vec    = irq;
    set_vec[0] = irq[0] | timeout_hit;
  end

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq (
    .clk         (clk),
    .rst         (rst),
    .set_vec     (set_vec),
    .clr_en      (clr_en),
    .clr_idx     (int_code),
    .any_pending (any_pending),
    .top_idx     (top_idx)
  );

  always_comb begin
    next_state = state;
    case (state)
      // 'armed' keeps the first post-reset cycle quiet before fetching.
      ST_FETCH:  next_state = armed ? ST_DECODE : ST_FETCH;
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC: begin
        case (ctrl.cls)
          CL_LOAD, CL_STORE: next_state = ST_MEM;
          CL_IN:             next_state = ST_IO_WAIT;
          CL_HALT:           next_state = ST_HALT;
          default:           next_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (memReady || timeout_hit) next_state = ST_WB;
      end
      ST_IO_WAIT: begin
        if (btn_rise) next_state = ST_WB;
      end
      ST_WB:   next_state = (any_pending && !kernel_mode) ? ST_INTR : ST_FETCH;
      ST_INTR: next_state = ST_FETCH;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_FETCH;
      armed        <= 1'b0;
      ctrl         <= '0;
      branch_taken <= 1'b0;
      mem_cnt      <= '0;
      mem_fault    <= 1'b0;
      bus_error    <= 1'b0;
      kernel_mode  <= 1'b1;
      int_code     <= '0;
      btn_q        <= 1'b0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
      btn_q <= btn;

      if (state == ST_DECODE) ctrl <= decode_instr(op, func);

      if (state == ST_EXEC) begin
        branch_taken <= isFalse;
        mem_fault    <= 1'b0;
      end

      if ((state == ST_MEM) && (next_state == ST_MEM)) mem_cnt <= mem_cnt + CNT_W'(1);
      else                                             mem_cnt <= '0;

      if (timeout_hit) begin
        mem_fault <= 1'b1;
        bus_error <= 1'b1;
      end

      // intCode and kernel mode are updated on INTR entry so they are
      // already valid while inta is high.
      if ((state == ST_WB) && (next_state == ST_INTR)) begin
        kernel_mode <= 1'b1;
        int_code    <= top_idx;
      end else if (state == ST_WB) begin
        if (ctrl.set_kernel)      kernel_mode <= 1'b1;
        else if (ctrl.clr_kernel) kernel_mode <= 1'b0;
      end
    end
  end

  always_comb begin
    irWrite  = (state == ST_FETCH) && armed;
    pcWrite  = (state == ST_WB) || (state == ST_INTR);
    regWrite = (state == ST_WB) && ctrl.reg_write && !mem_fault;
    memRead  = (state == ST_MEM) && (ctrl.cls == CL_LOAD);
    memWrite = (state == ST_MEM) && (ctrl.cls == CL_STORE);
    inta     = (state == ST_INTR);
    isHalt   = (state == ST_HALT);
    pcSource = PC_INC;
    if (state == ST_INTR) begin
      pcSource = PC_VECTOR;
    end else if (state == ST_WB) begin
      if (ctrl.is_cond) pcSource = branch_taken ? PC_BRANCH : PC_INC;
      else              pcSource = ctrl.pc_src;
    end
  end

  assign regDest      = ctrl.reg_dest;
  assign regWrtSelect = ctrl.wrt_sel;
  assign isRegAluOp   = ctrl.alu_src_reg;
  assign aluOp        = ctrl.alu_op;
  assign intCode      = int_code;
  assign kernelMode   = kernel_mode;
  assign busError     = bus_error;

endmodule
`default_nettype wire
